// File: rtl/mrf_nr_nw_sync_rd_pkg.sv
// Shared helpers for the multi-read, multi-write register file.
package mrf_nr_nw_sync_rd_pkg;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/mrf_wport_sel.sv
// Resolves which write port (if any) targets a query address; the highest index wins.
module mrf_wport_sel #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int NUM_WRITE = 2
) (
    input  logic [NUM_WRITE-1:0]    we,
    input  logic [AW*NUM_WRITE-1:0] waddr,
    input  logic [DW*NUM_WRITE-1:0] wdata,
    input  logic [AW-1:0]           qaddr,
    output logic                    hit,
    output logic [DW-1:0]           data
);

    // Ascending scan so later (higher-index) matches overwrite earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (we[j] && (waddr[j*AW +: AW] == qaddr)) begin
                hit  = 1'b1;
                data = wdata[j*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/mrf_nr_nw_sync_rd.sv
// Multi-port register file: NUM_WRITE write ports, NUM_READ registered read ports
// with write-first bypass and a per-port valid flag.
module mrf_nr_nw_sync_rd
    import mrf_nr_nw_sync_rd_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int NUM_WRITE = 2,
    parameter int NUM_READ  = 2,
    parameter logic [DW*(1<<AW)-1:0] RST_VECTOR = '0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_WRITE-1:0]    WE,
    input  logic [AW*NUM_WRITE-1:0] WADDR,
    input  logic [DW*NUM_WRITE-1:0] WDATA,
    input  logic [NUM_READ-1:0]     RE,
    input  logic [AW*NUM_READ-1:0]  RADDR,
    output logic [DW*NUM_READ-1:0]  RDATA,
    output logic [NUM_READ-1:0]     RVALID
);

    localparam int DEPTH = int'(depth_of(AW));

    logic [DW-1:0]                mem [DEPTH];
    logic [DEPTH-1:0]             ent_hit;
    logic [DEPTH-1:0][DW-1:0]     ent_data;
    logic [NUM_READ-1:0]          rd_hit;
    logic [NUM_READ-1:0][DW-1:0]  rd_data;
    logic [NUM_READ-1:0][DW-1:0]  rdata_q;
    logic [NUM_READ-1:0]          rvalid_q;

    // Per-entry write resolution: each entry asks "who writes me?"
    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        mrf_wport_sel #(.DW(DW), .AW(AW), .NUM_WRITE(NUM_WRITE)) u_sel (
            .we    (WE),
            .waddr (WADDR),
            .wdata (WDATA),
            .qaddr (AW'(e)),
            .hit   (ent_hit[e]),
            .data  (ent_data[e])
        );
    end

    // Per-read-port bypass lookup.
    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        mrf_wport_sel #(.DW(DW), .AW(AW), .NUM_WRITE(NUM_WRITE)) u_sel (
            .we    (WE),
            .waddr (WADDR),
            .wdata (WDATA),
            .qaddr (RADDR[k*AW +: AW]),
            .hit   (rd_hit[k]),
            .data  (rd_data[k])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int e = 0; e < DEPTH; e++)
                mem[e] <= RST_VECTOR[e*DW +: DW];
        end else begin
            for (int e = 0; e < DEPTH; e++)
                if (ent_hit[e]) mem[e] <= ent_data[e];
        end
    end

    // Held data is never re-flagged: RVALID tracks RE of the previous edge only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            for (int k = 0; k < NUM_READ; k++) begin
                rvalid_q[k] <= RE[k];
                if (RE[k])
                    rdata_q[k] <= rd_hit[k] ? rd_data[k] : mem[RADDR[k*AW +: AW]];
            end
        end
    end

    assign RDATA  = rdata_q;
    assign RVALID = rvalid_q;

endmodule

// File: tb/tb_mrf_nr_nw_sync_rd.sv
// Directed + randomized bench for mrf_nr_nw_sync_rd against an array-based reference model.
module tb_mrf_nr_nw_sync_rd;

    localparam int DW = 32, AW = 5, NW = 2, NR = 2, DEPTH = 32;
    localparam logic [DW*DEPTH-1:0] RV = {{(DW*DEPTH-32){1'b0}}, 32'h33} << (3*DW);

    logic              CLK = 1'b0;
    logic              RST;
    logic [NW-1:0]     WE;
    logic [AW*NW-1:0]  WADDR;
    logic [DW*NW-1:0]  WDATA;
    logic [NR-1:0]     RE;
    logic [AW*NR-1:0]  RADDR;
    logic [DW*NR-1:0]  RDATA;
    logic [NR-1:0]     RVALID;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mmem [DEPTH];
    logic [DW-1:0] exp_rdata [NR];
    logic          exp_rvalid [NR];

    mrf_nr_nw_sync_rd #(
        .DW(DW), .AW(AW), .NUM_WRITE(NW), .NUM_READ(NR), .RST_VECTOR(RV)
    ) dut (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .RE(RE), .RADDR(RADDR), .RDATA(RDATA), .RVALID(RVALID)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        RST = 1'b0; WE = '0; WADDR = '0; WDATA = '0; RE = '0; RADDR = '0;
    endtask

    task automatic wr(input int j, input int a, input logic [DW-1:0] d);
        WE[j] = 1'b1; WADDR[j*AW +: AW] = AW'(a); WDATA[j*DW +: DW] = d;
    endtask

    task automatic rd(input int k, input int a);
        RE[k] = 1'b1; RADDR[k*AW +: AW] = AW'(a);
    endtask

    // Reference: a read sees storage as it stands after this edge's writes,
    // which are applied in port order so the last port overrides.
    task automatic cyc(input string tag);
        if (RST) begin
            for (int e = 0; e < DEPTH; e++) mmem[e] = RV[e*DW +: DW];
            for (int k = 0; k < NR; k++) begin
                exp_rdata[k] = '0;
                exp_rvalid[k] = 1'b0;
            end
        end else begin
            for (int j = 0; j < NW; j++)
                if (WE[j]) mmem[WADDR[j*AW +: AW]] = WDATA[j*DW +: DW];
            for (int k = 0; k < NR; k++) begin
                if (RE[k]) exp_rdata[k] = mmem[RADDR[k*AW +: AW]];
                exp_rvalid[k] = RE[k];
            end
        end
        @(posedge CLK);
        #1;
        for (int k = 0; k < NR; k++) begin
            chk($sformatf("%s.rdata%0d", tag, k), RDATA[k*DW +: DW], exp_rdata[k]);
            chk($sformatf("%s.rvalid%0d", tag, k), DW'(RVALID[k]), DW'(exp_rvalid[k]));
        end
    endtask

    initial begin
        idle();
        RST = 1'b1;
        cyc("rst0");
        cyc("rst1");
        chk("rst_rvalid", DW'(RVALID), 32'd0);

        idle(); rd(0, 3); rd(1, 4);
        cyc("rd_rst_vals");
        chk("rd3_const", RDATA[31:0], 32'h33);
        chk("rvalid11", DW'(RVALID), 32'd3);
        idle();
        cyc("hold");
        chk("hold_rd0", RDATA[31:0], 32'h33);
        chk("hold_rvalid", DW'(RVALID), 32'd0);

        idle(); wr(0, 7, 32'hAAAA_0001); rd(0, 7);
        cyc("bypass");
        chk("bypass_const", RDATA[31:0], 32'hAAAA_0001);
        idle(); rd(0, 7);
        cyc("read7");

        idle(); wr(0, 9, 32'h1111); wr(1, 9, 32'h2222); rd(1, 9);
        cyc("waw");
        chk("waw_const", RDATA[63:32], 32'h2222);
        idle(); rd(0, 9);
        cyc("read9");
        chk("read9_const", RDATA[31:0], 32'h2222);

        idle(); wr(0, 10, 32'h10); wr(1, 11, 32'h11);
        cyc("par_wr");
        idle(); rd(0, 10); rd(1, 11);
        cyc("par_rd");
        chk("par_rd_const", RDATA, 64'h0000_0011_0000_0010);

        idle(); rd(0, 3); rd(1, 3);
        cyc("same_addr");

        idle(); wr(0, 3, 32'hDEAD); rd(0, 3);
        cyc("pre_rst");
        chk("pre_rst_const", RDATA[31:0], 32'hDEAD);
        idle(); RST = 1'b1; wr(0, 3, 32'hBEEF); rd(0, 3);
        cyc("mid_rst");
        chk("mid_rst_rvalid", DW'(RVALID), 32'd0);
        chk("mid_rst_rdata0", RDATA[31:0], 32'd0);
        idle(); rd(0, 3);
        cyc("post_rst");
        chk("post_rst_const", RDATA[31:0], 32'h33);

        // Random traffic; narrow address range most of the time to force collisions.
        for (int n = 0; n < 400; n++) begin
            idle();
            RST = ($urandom_range(0, 59) == 0);
            for (int j = 0; j < NW; j++)
                if ($urandom_range(0, 1) == 1)
                    wr(j, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5),
                       $urandom());
            for (int k = 0; k < NR; k++)
                if ($urandom_range(0, 2) != 0)
                    rd(k, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5));
            cyc("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mrf_nr_nw_sync_rd.md
Name: mrf_nr_nw_sync_rd

Overview:
Multi-read-port register file that pairs with the team's multi-write-port flat-dump register file. It provides NUM_READ independent addressed read ports with registered (1-cycle) outputs and a per-port valid flag. Write-to-read bypass lets a read issued in the same cycle as a write return the new data. It is intended for the CPU GPR and CSR shadow files, where the pipeline needs addressed reads rather than a full flat dump.

Parameters:
DW, 32, data width per entry
AW, 5, address width; depth = 1<<AW; AW>=1 required
NUM_WRITE, 2, write ports; a higher index has higher priority on WAW
NUM_READ, 2, read ports
RST_VECTOR, all-zero, DW*(1<<AW) bits; entry j reset value = RST_VECTOR[j*DW +: DW]

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
WE  in  NUM_WRITE  per-port write enable
WADDR  in  AW*NUM_WRITE  write address, port j at [j*AW +: AW]
WDATA  in  DW*NUM_WRITE  write data, port j at [j*DW +: DW]
RE  in  NUM_READ  per-port read enable
RADDR  in  AW*NUM_READ  read address, port k at [k*AW +: AW]
RDATA  out  DW*NUM_READ  registered read data, port k at [k*DW +: DW]
RVALID  out  NUM_READ  RDATA[k] was loaded on the previous edge

Behaviour:
- Reset: one clock; reset is synchronous and active-high (RST sampled on the rising edge of CLK).
  - On reset: storage entry j <= RST_VECTOR slice j; RDATA <= 0; RVALID <= 0.
  - All WE and RE inputs are ignored in a reset cycle. This also applies to reset mid-operation: in-flight reads are dropped and RVALID is 0 on the next cycle.
- Write, at each non-reset edge, for every j with WE[j]=1: entry WADDR[j] <= WDATA[j].
  - If several ports hit the same address, the highest index j wins.
  - Writes to different addresses all commit in the same edge.
- Read latency is exactly 1 cycle. If RE[k]=1 at edge t, then RDATA[k] is valid after t and RVALID[k]=1 for that cycle.
- If RE[k]=0 at edge t: RDATA[k] holds its previous value and RVALID[k] <= 0.
- Bypass (write-first). The value loaded into RDATA[k] at edge t is:
  - WDATA[j] of the highest-index j with WE[j]=1 and WADDR[j]==RADDR[k] at t, if any such j exists;
  - otherwise the current storage entry RADDR[k].
  The result is identical to a read of storage after the edge.
- Read ports are fully independent. Several ports may read the same address in the same cycle.
- No illegal address: AW bits fully cover the depth, so there are no range checks.
- No combinational path from any input to RDATA or RVALID.
- There is no ready/backpressure. The consumer must capture RDATA in the RVALID cycle or re-issue RE. Held data is not re-flagged valid.

Decomposition:
- No shared package is required. Depth is derived locally as 1<<AW.
- One natural combinational sub-module: mrf_wport_sel.
  - Inputs: WE, WADDR, WDATA, and one query address.
  - Outputs: hit flag and the winning WDATA, using highest-index priority.
  - Instantiated once per read port for bypass.
  - Reused for storage write priority with the query address set to each entry index (generate loop).
- Top-level content: storage array, reset logic, and the RDATA/RVALID registers.

Test Plan (DW=32, AW=5, NUM_WRITE=2, NUM_READ=2, RST_VECTOR entry3=0x0000_0033, others 0):
- Reset, then RE=2'b11 with RADDR0=3, RADDR1=4 -> next cycle RDATA0=0x33, RDATA1=0, RVALID=2'b11; cycle after with RE=0 -> RVALID=0, RDATA held.
- WE0=1, WADDR0=7, WDATA0=0xAAAA_0001, and in the same cycle RE0=1, RADDR0=7 -> RDATA0=0xAAAA_0001 next cycle (bypass); a later read of 7 also returns 0xAAAA_0001.
- WAW: WE=2'b11, both WADDR=9, WDATA0=0x1111, WDATA1=0x2222, with RE1=1 on addr 9 in the same cycle -> RDATA1=0x2222; a later read of 9 returns 0x2222.
- Parallel writes to 10 and 11 (0x10, 0x11), then a read of 10 on port 0 and 11 on port 1 -> 0x10 and 0x11, both valid.
- Both ports read addr 3 in the same cycle -> both return 0x33.
- Write 0xDEAD to addr 3 and issue RE0=1 on addr 3, then assert RST the next cycle with RE0=1 and a write of 0xBEEF to addr 3 -> after reset RVALID=0, RDATA=0; a subsequent read of addr 3 returns 0x33, not 0xDEAD or 0xBEEF.
